// File: rtl/sha3_pkg.sv
// Shared types, codes and helpers for the SHA-3 sequencer and its digest drain.
package sha3_pkg;

    localparam int unsigned HASH_W = 512;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned DCNT_W = 5;
    localparam int unsigned KIDX_W = 4;
    localparam int unsigned RATE_W = 11;

    localparam logic [1:0] OUT_512 = 2'b00;
    localparam logic [1:0] OUT_384 = 2'b01;
    localparam logic [1:0] OUT_256 = 2'b10;
    localparam logic [1:0] OUT_224 = 2'b11;

    localparam int unsigned RATE_512 = 576;
    localparam int unsigned RATE_384 = 832;
    localparam int unsigned RATE_256 = 1088;
    localparam int unsigned RATE_224 = 1152;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        LAST,
        WAIT_HASH,
        DRAIN
    } seq_state_e;

    // Command fields captured on start.
    typedef struct packed {
        logic [1:0] out_size;
        logic [1:0] len_lo;
    } seq_cmd_t;

    // Number of 32-bit digest words for an output-size code.
    function automatic logic [DCNT_W-1:0] digest_words(input logic [1:0] out_size);
        case (out_size)
            OUT_512: return DCNT_W'(16);
            OUT_384: return DCNT_W'(12);
            OUT_256: return DCNT_W'(8);
            default: return DCNT_W'(7);
        endcase
    endfunction

    // Sponge bitrate for an output-size code.
    function automatic logic [RATE_W-1:0] rate_bits(input logic [1:0] out_size);
        case (out_size)
            OUT_512: return RATE_W'(RATE_512);
            OUT_384: return RATE_W'(RATE_384);
            OUT_256: return RATE_W'(RATE_256);
            default: return RATE_W'(RATE_224);
        endcase
    endfunction

endpackage

// File: rtl/sha3_digest_drain.sv
// Captures the 512-bit permutation state and serialises the digest MSB-first
// as 32-bit valid/ready words, flagging the final word.
module sha3_digest_drain
    import sha3_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [HASH_W-1:0] hash_i,
    input  logic [DCNT_W-1:0] words_i,
    input  logic              en_i,
    input  logic              dig_ready_i,
    output logic [WORD_W-1:0] dig_data_o,
    output logic              dig_valid_o,
    output logic              dig_last_o,
    output logic              last_hs_o
);

    logic [HASH_W-1:0] hash_q, hash_d;
    logic [KIDX_W-1:0] k_q, k_d;
    logic [KIDX_W-1:0] last_q, last_d;
    logic              at_last;

    assign at_last = (k_q == last_q);

    // Shift the captured state left one word per handshake; the final index holds.
    always_comb begin
        hash_d = hash_q;
        k_d    = k_q;
        last_d = last_q;
        if (load_i) begin
            hash_d = hash_i;
            k_d    = '0;
            last_d = KIDX_W'(words_i - DCNT_W'(1));
        end else if (en_i && dig_ready_i && !at_last) begin
            hash_d = {hash_q[HASH_W-WORD_W-1:0], {WORD_W{1'b0}}};
            k_d    = k_q + KIDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hash_q <= '0;
            k_q    <= '0;
            last_q <= '0;
        end else begin
            hash_q <= hash_d;
            k_q    <= k_d;
            last_q <= last_d;
        end
    end

    assign dig_valid_o = en_i;
    assign dig_data_o  = en_i ? hash_q[HASH_W-1 -: WORD_W] : '0;
    assign dig_last_o  = en_i & at_last;
    assign last_hs_o   = en_i & dig_ready_i & at_last;

endmodule

// File: rtl/sha3_seq_ctrl.sv
// SHA-3 sequencer: clears the core, feeds the padder word by word with
// last-word marking, then drains the digest sized by the output length.
module sha3_seq_ctrl
    import sha3_pkg::*;
#(
    parameter int unsigned LEN_W      = 32,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        out_size,
    input  logic [LEN_W-1:0]  len_bytes,
    output logic              busy,
    output logic              done,
    input  logic [31:0]       msg_data,
    input  logic              msg_valid,
    output logic              msg_ready,
    output logic              core_rst,
    output logic [31:0]       pad_in,
    output logic              pad_in_ready,
    output logic              pad_is_last,
    output logic [1:0]        pad_byte_num,
    input  logic              pad_buffer_full,
    input  logic [511:0]      hash,
    input  logic              hash_valid,
    output logic [31:0]       dig_data,
    output logic              dig_valid,
    input  logic              dig_ready,
    output logic              dig_last
);

    localparam int unsigned WC_W = LEN_W - 2;
    localparam int unsigned CC_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    seq_state_e      state_q, state_d;
    seq_cmd_t        cmd_q, cmd_d;
    logic [WC_W-1:0] w_q, w_d;
    logic [CC_W-1:0] clr_q, clr_d;
    logic            done_q, done_d;
    logic            drain_load;
    logic            drain_last_hs;
    logic            last_take;

    // Final padder beat: a zero word when the length is word-aligned, else the next message word.
    assign last_take = ((cmd_q.len_lo == 2'd0) | msg_valid) & ~pad_buffer_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        w_d        = w_q;
        clr_d      = clr_q;
        done_d     = 1'b0;
        drain_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d.out_size = out_size;
                    cmd_d.len_lo   = len_bytes[1:0];
                    w_d            = len_bytes[LEN_W-1:2];
                    clr_d          = '0;
                    state_d        = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_q == CC_W'(CLR_CYCLES - 1)) begin
                    state_d = (w_q != '0) ? FEED : LAST;
                end else begin
                    clr_d = clr_q + CC_W'(1);
                end
            end
            FEED: begin
                if (msg_valid && !pad_buffer_full) begin
                    if (w_q <= WC_W'(1)) begin
                        w_d     = '0;
                        state_d = LAST;
                    end else begin
                        w_d = w_q - WC_W'(1);
                    end
                end
            end
            LAST: begin
                if (last_take) begin
                    state_d = WAIT_HASH;
                end
            end
            WAIT_HASH: begin
                if (hash_valid) begin
                    drain_load = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last_hs) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q  <= '0;
            w_q    <= '0;
            clr_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            w_q    <= w_d;
            clr_q  <= clr_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        busy         = (state_q != IDLE);
        done         = done_q;
        core_rst     = reset | (state_q == CLEAR);
        msg_ready    = 1'b0;
        pad_in       = '0;
        pad_in_ready = 1'b0;
        pad_is_last  = 1'b0;
        pad_byte_num = 2'd0;
        case (state_q)
            FEED: begin
                pad_in       = msg_data;
                pad_in_ready = msg_valid;
                msg_ready    = ~pad_buffer_full;
            end
            LAST: begin
                if (cmd_q.len_lo != 2'd0) begin
                    pad_in       = msg_data;
                    pad_in_ready = msg_valid;
                    msg_ready    = ~pad_buffer_full;
                end else begin
                    pad_in_ready = 1'b1;
                end
                // Last marking is withheld whenever the padder is full.
                pad_is_last  = pad_in_ready & ~pad_buffer_full;
                pad_byte_num = pad_is_last ? cmd_q.len_lo : 2'd0;
            end
            default: ;
        endcase
    end

    sha3_digest_drain u_drain (
        .clk         (clk),
        .reset       (reset),
        .load_i      (drain_load),
        .hash_i      (hash),
        .words_i     (digest_words(cmd_q.out_size)),
        .en_i        (state_q == DRAIN),
        .dig_ready_i (dig_ready),
        .dig_data_o  (dig_data),
        .dig_valid_o (dig_valid),
        .dig_last_o  (dig_last),
        .last_hs_o   (drain_last_hs)
    );

endmodule

// File: tb/tb_sha3_seq_ctrl.sv
// Scoreboard bench for sha3_seq_ctrl: padder beats and digest words are
// predicted when a job is launched and compared as the DUT produces them.
module tb_sha3_seq_ctrl;

    logic         clk = 1'b0;
    logic         reset, start, msg_valid, pad_buffer_full, hash_valid, dig_ready;
    logic [1:0]   out_size;
    logic [31:0]  len_bytes, msg_data;
    logic [511:0] hash;
    logic         busy, done, msg_ready, core_rst, pad_in_ready, pad_is_last;
    logic         dig_valid, dig_last;
    logic [1:0]   pad_byte_num;
    logic [31:0]  pad_in, dig_data;

    always #5 clk = ~clk;

    sha3_seq_ctrl #(.LEN_W(32), .CLR_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .out_size(out_size), .len_bytes(len_bytes),
        .busy(busy), .done(done), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .core_rst(core_rst), .pad_in(pad_in),
        .pad_in_ready(pad_in_ready), .pad_is_last(pad_is_last), .pad_byte_num(pad_byte_num),
        .pad_buffer_full(pad_buffer_full), .hash(hash), .hash_valid(hash_valid),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_last(dig_last)
    );

    typedef struct packed { logic [31:0] data; logic last; logic [1:0] bn; } pad_t;
    typedef struct packed { logic [31:0] data; logic last; } dig_t;

    pad_t        exp_pad[$];
    dig_t        exp_dig[$];
    logic [31:0] msg_src[$];
    logic [31:0] job_words[$];
    pad_t        pe;
    dig_t        de;
    int checks = 0, errors = 0;
    int msg_consumed = 0, pad_xfers = 0, dig_hs = 0, done_cnt = 0, clr_cycles = 0;
    int done_snap = 0, job_nbeats = 0, job_words_d = 0;
    bit pad_last_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    function automatic int dwords(input logic [1:0] s);
        case (s)
            2'b00:   return 16;
            2'b01:   return 12;
            2'b10:   return 8;
            default: return 7;
        endcase
    endfunction

    // Message source: presents the head of msg_src, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (msg_src.size() > 0) begin
            msg_valid = 1'b1;
            msg_data  = msg_src[0];
        end else begin
            msg_valid = 1'b0;
            msg_data  = '0;
        end
    end

    // Monitors sample at the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (busy && core_rst) clr_cycles++;
            if (done) done_cnt++;
            if (msg_valid && msg_ready) begin
                msg_consumed++;
                if (msg_src.size() > 0) msg_src.delete(0);
            end
            if (pad_buffer_full) begin
                checks++;
                if (pad_is_last !== 1'b0) begin
                    errors++;
                    $display("FAIL last_while_full got %b exp 0", pad_is_last);
                end
            end
            if (pad_in_ready && !pad_buffer_full) begin
                pad_xfers++;
                checks++;
                if (exp_pad.size() == 0) begin
                    errors++;
                    $display("FAIL pad_unexpected got %h/%b/%0d exp none", pad_in, pad_is_last, pad_byte_num);
                end else begin
                    pe = exp_pad.pop_front();
                    if ({pad_in, pad_is_last, pad_byte_num} !== pe) begin
                        errors++;
                        $display("FAIL pad_xfer got %h/%b/%0d exp %h/%b/%0d",
                                 pad_in, pad_is_last, pad_byte_num, pe.data, pe.last, pe.bn);
                    end
                end
                if (pad_is_last) pad_last_seen = 1;
            end
            if (prev_stall && dig_valid) begin
                checks++;
                if (dig_data !== prev_data) begin
                    errors++;
                    $display("FAIL dig_stable got %h exp %h", dig_data, prev_data);
                end
            end
            if (dig_valid && dig_ready) begin
                dig_hs++;
                checks++;
                if (exp_dig.size() == 0) begin
                    errors++;
                    $display("FAIL dig_unexpected got %h exp none", dig_data);
                end else begin
                    de = exp_dig.pop_front();
                    if ({dig_data, dig_last} !== de) begin
                        errors++;
                        $display("FAIL dig_word got %h/%b exp %h/%b", dig_data, dig_last, de.data, de.last);
                    end
                end
            end
            prev_stall = dig_valid && !dig_ready;
            prev_data  = dig_data;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int n);
        int t;
        t = 0;
        while (pad_xfers < n && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (pad_xfers < n) begin
            errors++;
            $display("FAIL wait_xfers got %0d exp %0d", pad_xfers, n);
        end
    endtask

    // Predict the padder beats, load the message source (plus one surplus beat) and pulse start.
    task automatic start_job(input logic [31:0] len, input logic [1:0] sz);
        int          nfull;
        logic [1:0]  lo;
        nfull = int'(len >> 2);
        lo    = len[1:0];
        for (int i = 0; i < nfull; i++) exp_pad.push_back({job_words[i], 1'b0, 2'd0});
        if (lo != 2'd0) exp_pad.push_back({job_words[nfull], 1'b1, lo});
        else            exp_pad.push_back({32'h0, 1'b1, 2'd0});
        job_nbeats  = nfull + ((lo != 2'd0) ? 1 : 0);
        job_words_d = dwords(sz);
        for (int i = 0; i < job_nbeats; i++) msg_src.push_back(job_words[i]);
        msg_src.push_back(32'hDEAD_BEEF);
        msg_consumed  = 0;
        pad_xfers     = 0;
        dig_hs        = 0;
        clr_cycles    = 0;
        pad_last_seen = 0;
        done_snap     = done_cnt;
        tick(1);
        start = 1'b1; len_bytes = len; out_size = sz;
        tick(1);
        start = 1'b0; len_bytes = ~len; out_size = ~sz;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b exp 1", busy); end
    endtask

    // Supply the hash, drain the digest (optionally with stalls / a stray start) and close the job.
    task automatic finish_job(input bit toggle, input bit start_in_drain);
        logic [511:0] h;
        int t;
        bit pulsed;
        t = 0;
        while (!pad_last_seen && t < 200) begin tick(1); t++; end
        checks++;
        if (!pad_last_seen) begin errors++; $display("FAIL pad_last_timeout got 0 exp 1"); end
        checks++;
        if (clr_cycles != 2) begin errors++; $display("FAIL clear_cycles got %0d exp 2", clr_cycles); end
        tick(2);
        checks++;
        if ({busy, dig_valid, pad_in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL wait_hash_outputs got %b exp 100", {busy, dig_valid, pad_in_ready});
        end
        for (int i = 0; i < 16; i++) h[511-32*i -: 32] = $urandom();
        for (int i = 0; i < job_words_d; i++)
            exp_dig.push_back({h[511-32*i -: 32], (i == job_words_d - 1) ? 1'b1 : 1'b0});
        hash = h; hash_valid = 1'b1;
        tick(1);
        hash_valid = 1'b0; hash = ~h;
        t = 0; pulsed = 0;
        while (done_cnt == done_snap && t < 400) begin
            dig_ready = toggle ? ((t % 3) != 2) : 1'b1;
            if (start_in_drain && dig_hs >= 1 && !pulsed) begin
                start = 1'b1; len_bytes = 32'd0; out_size = 2'b11; pulsed = 1;
            end else begin
                start = 1'b0;
            end
            tick(1);
            t++;
        end
        start = 1'b0; dig_ready = 1'b1;
        checks++;
        if (done_cnt == done_snap) begin errors++; $display("FAIL done_timeout got 0 exp 1"); end
        tick(3);
        checks++;
        if (done_cnt - done_snap != 1) begin errors++; $display("FAIL done_pulses got %0d exp 1", done_cnt - done_snap); end
        checks++;
        if (dig_hs != job_words_d) begin errors++; $display("FAIL dig_count got %0d exp %0d", dig_hs, job_words_d); end
        checks++;
        if (exp_dig.size() != 0 || exp_pad.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d/%0d exp 0/0", exp_pad.size(), exp_dig.size());
        end
        checks++;
        if (msg_consumed != job_nbeats) begin errors++; $display("FAIL msg_beats got %0d exp %0d", msg_consumed, job_nbeats); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b exp 0", busy); end
        msg_src.delete();
        exp_pad.delete();
        exp_dig.delete();
    endtask

    task automatic test_reset();
        tick(3);
        @(negedge clk);
        checks++;
        if ({busy, done, msg_ready, pad_in_ready, pad_is_last, pad_byte_num, dig_valid, dig_last} !== 9'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0",
                     {busy, done, msg_ready, pad_in_ready, pad_is_last, pad_byte_num, dig_valid, dig_last});
        end
        checks++;
        if ({pad_in, dig_data} !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {pad_in, dig_data}); end
        checks++;
        if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %b exp 1", core_rst); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_rst, busy} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b exp 00", {core_rst, busy}); end
        tick(1);
    endtask

    task automatic test_empty_msg();
        job_words.delete();
        start_job(32'd0, 2'b10);
        finish_job(0, 0);
    endtask

    task automatic test_partial_word();
        job_words = '{32'h6162_6364, 32'h6566_6700};
        start_job(32'd7, 2'b00);
        finish_job(0, 0);
    endtask

    task automatic test_aligned_last_with_full();
        job_words = '{32'hA5A5_0001, 32'h5A5A_0002};
        start_job(32'd8, 2'b11);
        wait_xfers(2);
        pad_buffer_full = 1'b1;
        tick(3);
        pad_buffer_full = 1'b0;
        finish_job(0, 0);
    endtask

    task automatic test_feed_backpressure();
        int x, m;
        job_words = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004, 32'h5000_0005};
        start_job(32'd20, 2'b10);
        wait_xfers(1);
        pad_buffer_full = 1'b1;
        x = pad_xfers; m = msg_consumed;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (msg_ready !== 1'b0) begin errors++; $display("FAIL bp_msg_ready got %b exp 0", msg_ready); end
        end
        @(posedge clk); #1;
        pad_buffer_full = 1'b0;
        checks++;
        if (pad_xfers != x || msg_consumed != m) begin
            errors++;
            $display("FAIL bp_hold got %0d/%0d exp %0d/%0d", pad_xfers, msg_consumed, x, m);
        end
        finish_job(1, 0);
    endtask

    task automatic test_start_ignored();
        job_words = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
        start_job(32'd12, 2'b01);
        wait_xfers(1);
        start = 1'b1; len_bytes = 32'd0; out_size = 2'b11;
        tick(1);
        start = 1'b0;
        finish_job(1, 1);
    endtask

    task automatic test_reset_mid();
        int snap;
        job_words = '{32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003};
        start_job(32'd12, 2'b00);
        wait_xfers(4);
        tick(1);
        checks++;
        if ({busy, pad_in_ready, msg_ready} !== 3'b100) begin
            errors++;
            $display("FAIL wait_hash_idle_pad got %b exp 100", {busy, pad_in_ready, msg_ready});
        end
        snap = done_cnt;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, dig_valid, core_rst} !== 4'b0) begin
            errors++;
            $display("FAIL after_mid_reset got %b exp 0000", {busy, done, dig_valid, core_rst});
        end
        tick(4);
        checks++;
        if (done_cnt != snap) begin errors++; $display("FAIL mid_reset_done got %0d exp %0d", done_cnt, snap); end
        msg_src.delete();
        exp_pad.delete();
        tick(1);
        job_words = '{32'h1122_3344};
        start_job(32'd4, 2'b01);
        finish_job(0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; out_size = 2'b00; len_bytes = '0;
        pad_buffer_full = 1'b0; hash = '0; hash_valid = 1'b0; dig_ready = 1'b1;
        msg_valid = 1'b0; msg_data = '0;
        test_reset();
        test_empty_msg();
        test_partial_word();
        test_aligned_last_with_full();
        test_feed_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
